// File: rtl/pixel_gain_ctrl.sv
// Key-stepped brightness gain for a packed multi-channel pixel stream.
// The gain level changes only at start of frame; the datapath saturates each channel.

module pixel_gain_key #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_step
);
  // state   | meaning
  // IDLE    | debounced key released, waiting for a stable press
  // HELD    | debounced key pressed, a stable release emits o_step

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_HELD} key_state_t;

  logic             r_meta;
  logic             r_sync;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  key_state_t       r_state;
  logic             r_step;

  // Synchroniser plus debounce: the stable state follows the synced key only
  // after it has held the same value for DB_CYCLES consecutive samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else begin
      r_meta <= i_key_n;
      r_sync <= r_meta;
      r_last <= r_sync;
      if (r_sync != r_last) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_TC) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_sync == r_last) && (r_cnt == CNT_TC)) begin
        r_stable <= r_sync;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_stable) begin
            r_state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (r_stable) begin
            r_state <= ST_IDLE;
            r_step  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_step = r_step;

endmodule

module pixel_gain_ctrl #(
  parameter int DW          = 8,
  parameter int N_CH        = 3,
  parameter int LEVEL_W     = 4,
  parameter int UNITY_SHIFT = 3,
  parameter int DEF_LEVEL   = 8,
  parameter int DB_CYCLES   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_up_n,
  input  logic                 key_dn_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [N_CH*DW-1:0]   in_data,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic [N_CH*DW-1:0]   out_data,
  output logic [LEVEL_W-1:0]   level_o
);

  localparam int PW = DW + LEVEL_W;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] DEF_LVL   = LEVEL_W'(DEF_LEVEL);
  localparam logic [PW-1:0]      PIX_MAX   = {{LEVEL_W{1'b0}}, {DW{1'b1}}};

  logic                      w_up_step;
  logic                      w_dn_step;
  logic                      w_sof_in;
  logic [LEVEL_W-1:0]        w_gain;
  logic [PW-1:0]             w_q;
  logic [N_CH*DW-1:0]        w_sat;

  logic [LEVEL_W-1:0]        r_pending;
  logic [LEVEL_W-1:0]        r_active;
  logic [N_CH-1:0][PW-1:0]   r_prod;
  logic                      r_v1;
  logic                      r_sof1;

  pixel_gain_key #(.DB_CYCLES(DB_CYCLES)) u_key_up (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (key_up_n),
    .o_step  (w_up_step)
  );

  pixel_gain_key #(.DB_CYCLES(DB_CYCLES)) u_key_dn (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (key_dn_n),
    .o_step  (w_dn_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= DEF_LVL;
    end else if (w_up_step && !w_dn_step && (r_pending != MAX_LEVEL)) begin
      r_pending <= r_pending + 1'b1;
    end else if (w_dn_step && !w_up_step && (r_pending != '0)) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  // The SOF pixel must already see the level being loaded, so bypass the register.
  assign w_sof_in = in_valid & in_sof;
  assign w_gain   = w_sof_in ? r_pending : r_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= DEF_LVL;
    end else if (w_sof_in) begin
      r_active <= r_pending;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
      r_sof1 <= 1'b0;
    end else begin
      r_v1   <= in_valid;
      r_sof1 <= w_sof_in;
      if (in_valid) begin
        for (int c = 0; c < N_CH; c++) begin
          r_prod[c] <= PW'(in_data[c*DW +: DW]) * PW'(w_gain);
        end
      end
    end
  end

  always_comb begin
    w_sat = '0;
    w_q   = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_q = r_prod[c] >> UNITY_SHIFT;
      w_sat[c*DW +: DW] = (w_q > PIX_MAX) ? {DW{1'b1}} : w_q[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= r_v1;
      out_sof   <= r_sof1;
      if (r_v1) begin
        out_data <= w_sat;
      end
    end
  end

  assign level_o = r_pending;

endmodule

// File: tb/tb_pixel_gain_ctrl.sv
// Directed bench for pixel_gain_ctrl: vector table for the datapath, hand
// sequences for key debounce, level clamping, frame-aligned level changes and reset.

module tb_pixel_gain_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_up_n;
  logic        key_dn_n;
  logic        in_valid;
  logic        in_sof;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_sof;
  logic [23:0] out_data;
  logic [3:0]  level_o;

  always #5 clk = ~clk;

  pixel_gain_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .key_up_n  (key_up_n),
    .key_dn_n  (key_dn_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_data  (out_data),
    .level_o   (level_o)
  );

  typedef struct {
    logic        sof;
    logic [23:0] din;
    logic [23:0] dexp;
  } vec_t;

  typedef struct {
    logic        sof;
    logic [23:0] d;
  } exp_t;

  vec_t tbl [15];
  exp_t q_exp [$];
  int   n_checks = 0;
  int   n_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!reset && out_valid) begin
      if (q_exp.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        e = q_exp.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_sof", 32'(out_sof), 32'(e.sof));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_range(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_sof   = tbl[i].sof;
      in_data  = tbl[i].din;
      e.sof    = tbl[i].sof;
      e.d      = tbl[i].dexp;
      q_exp.push_back(e);
      step();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    steps(3);
    check("all_pixels_out", 32'(q_exp.size()), 32'(0));
  endtask

  task automatic press(input logic up, input logic dn);
    key_up_n = ~up;
    key_dn_n = ~dn;
    steps(32);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    steps(32);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // level 8 (unity)
    tbl[0]  = '{1'b1, 24'hFF8040, 24'hFF8040};
    tbl[1]  = '{1'b0, 24'h123456, 24'h123456};
    tbl[2]  = '{1'b0, 24'h000000, 24'h000000};
    tbl[3]  = '{1'b0, 24'hFFFFFF, 24'hFFFFFF};
    // pending 9, active still 8 until sof
    tbl[4]  = '{1'b0, 24'h808080, 24'h808080};
    tbl[5]  = '{1'b1, 24'h808080, 24'h909090};
    tbl[6]  = '{1'b0, 24'h10FF40, 24'h12FF48};
    tbl[7]  = '{1'b0, 24'h080701, 24'h090701};
    // level 15
    tbl[8]  = '{1'b1, 24'hFF4080, 24'hFF78F0};
    tbl[9]  = '{1'b0, 24'h881189, 24'hFF1FFF};
    tbl[10] = '{1'b1, 24'h408010, 24'h78F01E};
    // pending 14 mid-frame: old gain, then new gain at sof
    tbl[11] = '{1'b0, 24'h408010, 24'h78F01E};
    tbl[12] = '{1'b1, 24'h408010, 24'h70E01C};
    // level 0
    tbl[13] = '{1'b1, 24'hFFFFFF, 24'h000000};
    tbl[14] = '{1'b0, 24'h123456, 24'h000000};

    reset    = 1'b1;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    steps(3);
    check("reset_level", 32'(level_o), 32'(8));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out_sof", 32'(out_sof), 32'(0));
    check("reset_out_data", 32'(out_data), 32'(0));
    reset = 1'b0;
    steps(2);

    send_range(0, 3);
    steps(5);
    check("hold_out_valid", 32'(out_valid), 32'(0));
    check("hold_out_data", 32'(out_data), 32'hFFFFFF);

    key_up_n = 1'b0;
    steps(10);
    key_up_n = 1'b1;
    steps(40);
    check("bounce_no_step", 32'(level_o), 32'(8));

    press(1'b1, 1'b0);
    check("up_once", 32'(level_o), 32'(9));
    send_range(4, 7);

    for (int p = 0; p < 10; p++) press(1'b1, 1'b0);
    check("up_clamp", 32'(level_o), 32'(15));
    send_range(8, 10);

    press(1'b0, 1'b1);
    check("down_mid_frame", 32'(level_o), 32'(14));
    send_range(11, 12);

    press(1'b1, 1'b1);
    check("both_keys", 32'(level_o), 32'(14));

    // reset with one pixel at the output register and one in stage 1
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_data  = 24'hABCDEF;
    step();
    in_sof   = 1'b0;
    in_data  = 24'h010203;
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'(0));
    check("midreset_level", 32'(level_o), 32'(8));
    steps(2);
    check("midreset_hold_valid", 32'(out_valid), 32'(0));
    reset = 1'b0;
    steps(5);
    check("postreset_no_stale", 32'(out_valid), 32'(0));
    check("postreset_level", 32'(level_o), 32'(8));

    for (int p = 0; p < 8; p++) press(1'b0, 1'b1);
    check("down_to_zero", 32'(level_o), 32'(0));
    press(1'b0, 1'b1);
    check("down_clamp", 32'(level_o), 32'(0));
    send_range(13, 14);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
